// File: rtl/txbf.sv
// ---------------------------------------------------------------------------
// txbf -- two-entry skid buffer between a producer and a bus consumer.
//
// The producer side sees a registered busy and the bus side sees registered
// data/valid. The bus busy may therefore arrive late in the cycle without
// creating any combinational path through this block.
//
// Ports
//   clk_i        single clock, rising edge
//   reset_ni     asynchronous active-low reset
//   flush_i      synchronous discard of all held entries
//   ip_data_i    producer data (DW bits)
//   ip_vld_i     producer data valid
//   ip_busy_o    registered busy back to the producer
//   bus_data_o   registered data to the bus (the "main" register)
//   bus_vld_o    registered valid to the bus
//   bus_busy_i   busy from the bus consumer
//   occupancy_o  number of held entries: 0, 1 or 2
// ---------------------------------------------------------------------------
module txbf #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          flush_i,
    input  logic [DW-1:0] ip_data_i,
    input  logic          ip_vld_i,
    output logic          ip_busy_o,
    output logic [DW-1:0] bus_data_o,
    output logic          bus_vld_o,
    input  logic          bus_busy_i,
    output logic [1:0]    occupancy_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          vld_q, busy_q;
    logic          in_xfer, out_xfer;

    // Handshakes use only the registered outputs, so the output flops never
    // see a combinational path from an input to an output.
    assign in_xfer  = ip_vld_i & ~busy_q;
    assign out_xfer = vld_q & ~bus_busy_i;

    // Next-state and datapath decision. The main register always holds the
    // oldest entry; skid only fills when main could not drain this cycle.
    // Flush wins over everything and drops whatever was being offered.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = ip_data_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = ip_data_i;
                    end else if (in_xfer) begin
                        skid_d  = ip_data_i;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Valid and busy get their own flops, loaded from the decoded next state,
    // so that each output comes straight off a register rather than a decoder.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= (state_d != EMPTY);
            busy_q  <= (state_d == FULL);
        end
    end

    assign bus_data_o  = main_q;
    assign bus_vld_o   = vld_q;
    assign ip_busy_o   = busy_q;
    assign occupancy_o = state_q;

endmodule

// File: tb/tb_txbf.sv
// ---------------------------------------------------------------------------
// tb_txbf -- directed self-checking bench for txbf.
// Inputs change 1 ns after each rising edge and outputs are sampled there,
// well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_txbf;

    logic       clk_i;
    logic       reset_ni;
    logic       flush_i;
    logic [7:0] ip_data_i;
    logic       ip_vld_i;
    logic       ip_busy_o;
    logic [7:0] bus_data_o;
    logic       bus_vld_o;
    logic       bus_busy_i;
    logic [1:0] occupancy_o;

    int check_count;
    int pass_count;

    txbf #(.DW(8)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (flush_i),
        .ip_data_i   (ip_data_i),
        .ip_vld_i    (ip_vld_i),
        .ip_busy_o   (ip_busy_o),
        .bus_data_o  (bus_data_o),
        .bus_vld_o   (bus_vld_o),
        .bus_busy_i  (bus_busy_i),
        .occupancy_o (occupancy_o)
    );

    // Free-running 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Present one cycle's inputs, let the edge happen, then step off it.
    task automatic applyStimulus(input logic vld, input logic [7:0] data,
                                 input logic bbusy, input logic flush);
        ip_vld_i   = vld;
        ip_data_i  = data;
        bus_busy_i = bbusy;
        flush_i    = flush;
        @(posedge clk_i);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        check_count = 0;
        pass_count  = 0;
        reset_ni    = 1'b0;
        flush_i     = 1'b0;
        ip_data_i   = 8'h00;
        ip_vld_i    = 1'b0;
        bus_busy_i  = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_vld",  bus_vld_o,   0);
        checkOutput("rst_busy", ip_busy_o,   0);
        checkOutput("rst_occ",  occupancy_o, 0);
        checkOutput("rst_data", bus_data_o,  0);
        reset_ni = 1'b1;

        // First in right after reset, visible next cycle.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkOutput("first_vld",  bus_vld_o,   1);
        checkOutput("first_data", bus_data_o,  8'h11);
        checkOutput("first_occ",  occupancy_o, 1);
        checkOutput("first_busy", ip_busy_o,   0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("first_drain", bus_vld_o, 0);

        // Back-to-back stream at full rate.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            checkOutput("stream_data", bus_data_o,  i);
            checkOutput("stream_occ",  occupancy_o, 1);
            checkOutput("stream_busy", ip_busy_o,   0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("stream_end", bus_vld_o, 0);

        // Skid fill under bus backpressure, then drain in order.
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0);
        checkOutput("bp_occ",  occupancy_o, 2);
        checkOutput("bp_busy", ip_busy_o,   1);
        checkOutput("bp_data", bus_data_o,  8'hA1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_hold_data", bus_data_o, 8'hA1);
        checkOutput("bp_hold_vld",  bus_vld_o,  1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bp_second", bus_data_o,  8'hA2);
        checkOutput("bp_unbusy", ip_busy_o,   0);
        checkOutput("bp_occ1",   occupancy_o, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bp_empty", bus_vld_o, 0);

        // Producer keeps offering 0xFF while full; it must be ignored.
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
            checkOutput("full_data", bus_data_o,  8'hB1);
            checkOutput("full_occ",  occupancy_o, 2);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_b2", bus_data_o, 8'hB2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_end", bus_vld_o, 0);

        // Flush while full, with data offered at the same time.
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0);
        checkOutput("pre_flush_occ", occupancy_o, 2);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        checkOutput("flush_vld",  bus_vld_o,   0);
        checkOutput("flush_occ",  occupancy_o, 0);
        checkOutput("flush_busy", ip_busy_o,   0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("flush_no33", bus_vld_o, 0);

        // Asynchronous reset between edges while holding one entry.
        applyStimulus(1'b1, 8'hD1, 1'b1, 1'b0);
        checkOutput("pre_rst_data", bus_data_o, 8'hD1);
        ip_vld_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        checkOutput("arst_vld",  bus_vld_o,   0);
        checkOutput("arst_data", bus_data_o,  0);
        checkOutput("arst_occ",  occupancy_o, 0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("post_rst_data", bus_data_o, 8'h5A);
        checkOutput("post_rst_occ",  occupancy_o, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_rst_end", bus_vld_o, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
